// File: rtl/pkt_fifo_ctrl.sv
// Packet-aware FIFO controller for an external dual-port RAM; a packet is readable only once its last word is committed.
// Latency: write lands in RAM on the handshake cycle; first read word is valid 2 edges after the committing edge.
// Backpressure: s_ready drops when the RAM holds DEPTH unissued words; a 2-entry output buffer absorbs m_ready stalls.
module pkt_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_abort,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH:0]   ram_din_a,
    output logic                  ram_we_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH:0]   ram_din_b,
    input  logic [DATA_WIDTH:0]   ram_dout_b,
    output logic [ADDR_WIDTH:0]   pkt_count,
    output logic                  ovf_drop
);

    // Pointer distance equal to the RAM depth; pointers carry one wrap bit.
    localparam logic [ADDR_WIDTH:0] DEPTH_V = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic {
        W_PASS,
        W_DISCARD
    } wstate_t;

    wstate_t               wstate;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   wr_cmt;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  run;
    logic                  full;
    logic                  oversize;
    logic                  wr_hs;
    logic                  commit;
    logic                  inflight;
    logic                  skid_vld;
    logic [DATA_WIDTH:0]   skid_q;
    logic                  pop;
    logic                  rd_done;
    logic                  issue;
    logic [2:0]            out_cnt;
    logic [2:0]            issue_lim;

    // Write-side handshake and RAM port A drive; RAM port B is read-only.
    always_comb begin
        full       = (wr_ptr - rd_ptr) == DEPTH_V;
        s_ready    = run && !s_abort && ((wstate == W_DISCARD) || !full);
        wr_hs      = s_valid && s_ready;
        ram_we_a   = wr_hs && (wstate == W_PASS);
        commit     = ram_we_a && s_last;
        // A full uncommitted packet with more words coming can never fit.
        oversize   = (wstate == W_PASS) && !s_abort && s_valid && !s_last &&
                     ((wr_ptr - wr_cmt) == DEPTH_V);
        ram_addr_a = wr_ptr[ADDR_WIDTH-1:0];
        ram_din_a  = {s_last, s_data};
        ram_we_b   = 1'b0;
        ram_din_b  = '0;
        ram_addr_b = rd_ptr[ADDR_WIDTH-1:0];
    end

    // Read issue: output buffer occupancy plus the word in flight must leave a slot.
    // A word leaving this cycle frees its slot in time, which keeps 1 word/cycle.
    always_comb begin
        pop       = m_valid && m_ready;
        rd_done   = pop && m_last;
        out_cnt   = {2'b00, m_valid} + {2'b00, skid_vld} + {2'b00, inflight};
        issue_lim = 3'd2 + {2'b00, pop};
        issue     = (rd_ptr != wr_cmt) && (out_cnt < issue_lim);
    end

    // s_ready stays low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Write FSM: tentative/committed pointers, abort rewind, oversize drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate   <= W_PASS;
            wr_ptr   <= '0;
            wr_cmt   <= '0;
            ovf_drop <= 1'b0;
        end else begin
            ovf_drop <= 1'b0;
            case (wstate)
                W_PASS: begin
                    if (s_abort) begin
                        wr_ptr <= wr_cmt;
                    end else if (oversize) begin
                        wr_ptr   <= wr_cmt;
                        ovf_drop <= 1'b1;
                        wstate   <= W_DISCARD;
                    end else if (wr_hs) begin
                        wr_ptr <= wr_ptr + PTR_ONE;
                        if (s_last) begin
                            wr_cmt <= wr_ptr + PTR_ONE;
                        end
                    end
                end
                W_DISCARD: begin
                    if (s_abort || (wr_hs && s_last)) begin
                        wstate <= W_PASS;
                    end
                end
                default: wstate <= W_PASS;
            endcase
        end
    end

    // Read pointer and the one-cycle RAM latency marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Committed-but-unread packet count; commit and read-out together cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count <= '0;
        end else begin
            case ({commit, rd_done})
                2'b10:   pkt_count <= pkt_count + PTR_ONE;
                2'b01:   pkt_count <= pkt_count - PTR_ONE;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    // Output buffer: head register drives m_*, skid register catches a word during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
            skid_vld <= 1'b0;
            skid_q   <= '0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (!m_valid) begin
                        {m_last, m_data} <= ram_dout_b;
                        m_valid          <= 1'b1;
                    end else begin
                        skid_q   <= ram_dout_b;
                        skid_vld <= 1'b1;
                    end
                end
                2'b01: begin
                    if (skid_vld) begin
                        {m_last, m_data} <= skid_q;
                        skid_vld         <= 1'b0;
                    end else begin
                        m_valid <= 1'b0;
                    end
                end
                2'b11: begin
                    if (skid_vld) begin
                        {m_last, m_data} <= skid_q;
                        skid_q           <= ram_dout_b;
                    end else begin
                        {m_last, m_data} <= ram_dout_b;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_fifo_ctrl.sv
// Randomized bench for pkt_fifo_ctrl with a packet-level scoreboard and a behavioural RAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// m_ready is driven held-low, held-high or 50% random depending on rdy_mode.
module tb_pkt_fifo_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_abort = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;
    logic          ram_we_a;
    logic [AW-1:0] ram_addr_a;
    logic [DW:0]   ram_din_a;
    logic          ram_we_b;
    logic [AW-1:0] ram_addr_b;
    logic [DW:0]   ram_din_b;
    logic [DW:0]   ram_dout_b = '0;
    logic [AW:0]   pkt_count;
    logic          ovf_drop;

    pkt_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready), .s_abort(s_abort),
        .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a),
        .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b), .ram_dout_b(ram_dout_b),
        .pkt_count(pkt_count), .ovf_drop(ovf_drop)
    );

    always #5 clk = ~clk;

    // Behavioural true dual-port RAM with a registered read on port B.
    logic [DW:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
        ram_dout_b <= mem[ram_addr_b];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state: words awaiting output, the open packet, committed write address.
    logic [DW:0] exp_q[$];
    logic [DW:0] part_q[$];
    int          exp_cnt = 0;
    int          wc = 0;
    bit          disc = 0;
    bit          exp_ovf = 0;
    bit          prev_stall = 0;
    bit          prev_mv = 0;
    logic [DW:0] prev_dat = '0;
    bit          lat_en = 0;
    int          last_edge = 0;
    int          n_out = 0;
    int          last_out_cyc = 0;
    int          rdy_mode = 0;

    // Scoreboard: checks this cycle's outputs, then applies the handshakes of the coming edge.
    always @(negedge clk) begin
        logic        hs;
        logic        exp_we;
        logic [DW:0] w;
        if (!rst_n) begin
            exp_q.delete();
            part_q.delete();
            exp_cnt = 0; wc = 0; disc = 0; exp_ovf = 0;
            prev_stall = 0; prev_mv = 0;
        end else begin
            hs = s_valid && s_ready;
            chk("ovf_drop", ovf_drop, exp_ovf);
            exp_ovf = 0;
            chk("pkt_count", pkt_count, exp_cnt);
            if (prev_stall) chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_dat});
            prev_stall = m_valid && !m_ready;
            prev_dat   = {m_last, m_data};
            if (lat_en && m_valid && !prev_mv) chk("first_word_latency", cyc - last_edge, 2);
            prev_mv = m_valid;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("out_unexpected_qsize", exp_q.size(), 1);
                end else begin
                    w = exp_q.pop_front();
                    chk("out_word", {m_last, m_data}, w);
                    if (w[DW]) exp_cnt--;
                    n_out++;
                    last_out_cyc = cyc;
                end
            end
            exp_we = hs && !disc;
            chk("ram_we_a", ram_we_a, exp_we);
            if (disc) begin
                if (s_abort || (hs && s_last)) disc = 0;
            end else if (s_abort) begin
                part_q.delete();
            end else if (exp_we) begin
                chk("ram_addr_a", ram_addr_a, (wc + part_q.size()) % DEPTH);
                chk("ram_din_a", ram_din_a, {s_last, s_data});
                part_q.push_back({s_last, s_data});
                if (s_last) begin
                    foreach (part_q[i]) exp_q.push_back(part_q[i]);
                    wc = (wc + part_q.size()) % DEPTH;
                    part_q.delete();
                    exp_cnt++;
                    last_edge = cyc + 1;
                end
            end else if (s_valid && !s_last && part_q.size() == DEPTH) begin
                part_q.delete();
                disc    = 1;
                exp_ovf = 1;
            end
        end
    end

    // Consumer: m_ready pattern selected by rdy_mode.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int n;
        bit done;
        n = 0;
        done = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!done && n < 3000) begin
            @(negedge clk);
            if (s_ready) done = 1;
            @(posedge clk);
            #1;
            n++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (!done) chk("s_ready_wait", {63'd0, done}, 64'd1);
    endtask

    task automatic do_abort(input logic [DW-1:0] d, input logic v);
        s_valid = v; s_data = d; s_abort = 1'b1;
        @(posedge clk);
        #1;
        s_abort = 1'b0; s_valid = 1'b0;
    endtask

    task automatic idle();
        s_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) chk("drain_timeout_qsize", exp_q.size(), 0);
    endtask

    task automatic set_rdy(input int mode);
        @(negedge clk);
        rdy_mode = mode;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        int c0;
        int base;
        int len;
        int abort_at;
        // Reset values.
        #3;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_ram_we_a", ram_we_a, 0);
        chk("rst_ram_we_b", ram_we_b, 0);
        chk("rst_ram_din_b", ram_din_b, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_ovf_drop", ovf_drop, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("s_ready_after_reset", s_ready, 1);

        // 3-word packet, exact first-word latency with an empty output path.
        set_rdy(1);
        lat_en = 1;
        send_beat(32'hA0, 1'b0);
        send_beat(32'hA1, 1'b0);
        send_beat(32'hA2, 1'b1);
        wait_drain();
        lat_en = 0;

        // Abort on beat 4 of a 5-word packet, then a clean 2-word packet.
        send_beat(32'hC0, 1'b0);
        send_beat(32'hC1, 1'b0);
        send_beat(32'hC2, 1'b0);
        do_abort(32'hC3, 1'b1);
        send_beat(32'hB0, 1'b0);
        send_beat(32'hB1, 1'b1);
        wait_drain();

        // 20 words without last before beat 20: oversize drop, then a normal packet.
        for (int i = 0; i < 20; i++) send_beat(32'hE00 + i, i == 19);
        send_beat(32'hD0, 1'b0);
        send_beat(32'hD1, 1'b1);
        wait_drain();

        // One-word packets with the consumer stalled. Two words already sit in the
        // output buffer (issued, so rd_ptr is past them); the RAM fills after 18.
        set_rdy(0);
        for (int i = 0; i < 18; i++) begin
            send_beat(32'h100 + i, 1'b1);
            if (i == 15) chk("pkt_count_16", pkt_count, 16);
        end
        chk("full_s_ready", s_ready, 0);
        chk("full_pkt_count", pkt_count, 18);
        base = n_out;
        set_rdy(1);
        c0 = cyc;
        for (int n = 0; n < 200 && n_out < base + 18; n++) begin
            @(posedge clk);
            #1;
        end
        chk("burst_count", n_out - base, 18);
        chk("burst_rate", last_out_cyc - c0, 17);
        wait_drain();

        // Random packets, gaps, aborts and 50% consumer stalls; pointers wrap many times.
        set_rdy(2);
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, DEPTH);
            abort_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
            for (int i = 0; i < len; i++) begin
                if (i == abort_at) begin
                    do_abort({p[15:0], i[15:0]}, 1'($urandom_range(0, 1)));
                    break;
                end
                if ($urandom_range(0, 3) == 0) idle();
                send_beat({p[15:0], i[15:0]}, i == len - 1);
            end
        end
        wait_drain();

        // Reset mid-packet with one packet committed and parked at the output.
        set_rdy(0);
        send_beat(32'hF0, 1'b0);
        send_beat(32'hF1, 1'b0);
        send_beat(32'hF2, 1'b1);
        send_beat(32'hF3, 1'b0);
        send_beat(32'hF4, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_m_valid", m_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_m_data", m_data, 0);
        chk("midrst_m_last", m_last, 0);
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_pkt_count", pkt_count, 0);
        chk("midrst_ram_we_a", ram_we_a, 0);
        chk("midrst_ovf_drop", ovf_drop, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_rdy(1);
        for (int i = 0; i < 4; i++) send_beat(32'h700 + i, i == 3);
        wait_drain();
        chk("final_pkt_count", pkt_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
